// File: rtl/read_arbiter.sv
// read_arbiter
// Round-robin arbiter/sequencer sharing one read engine (go/ds handshake)
// between NREQ requesters. One requester owns the engine at a time: it is
// granted, a single-cycle go is issued, the arbiter waits for ds (or a
// watchdog timeout), reports done/err to the owner and rotates priority so
// the requester after the owner is scanned first next time.

module read_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDX_W   = 2,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             ds,
    output logic             go,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] owner,
    output logic [NREQ-1:0]  done_o,
    output logic [NREQ-1:0]  err_o,
    output logic             busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("read_arbiter: NREQ must be in 2..16");
    end

    if (IDX_W != $clog2(NREQ)) begin : g_bad_idx_w
        $error("read_arbiter: IDX_W must equal clog2(NREQ)");
    end

    // The watchdog counter must be able to reach TMO_MAX-1 without wrapping.
    if (TMO_MAX < 1 || TMO_MAX >= (1 << TMO_W)) begin : g_bad_tmo
        $error("read_arbiter: TMO_MAX must satisfy 1 <= TMO_MAX < 2**TMO_W");
    end

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    // Last value of the watchdog before a timeout is declared.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);
    localparam logic [IDX_W:0]   NREQ_EXT = (IDX_W + 1)'(NREQ);

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [TMO_W-1:0] cnt;

    // Round-robin search signals
    logic [NREQ-1:0]  req_rot;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   win_sum;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] owner_inc;

    // Transition qualifiers
    logic grant_fire;
    logic wait_done;
    logic wait_tmo;
    logic in_release;

    // Rotate requests so bit 0 is the highest-priority requester (ptr), pick
    // the first set bit, and map the offset back to an absolute index.
    always_comb begin
        // NOTE: every variable written here gets a value before any
        // conditional update, so no path leaves it unassigned and no latch
        // is inferred.
        req_rot = NREQ'({req, req} >> ptr);
        offset  = '0;
        // Descending scan: the lowest set offset is the last one written.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, offset};
        if (win_sum >= NREQ_EXT) begin
            win_sum = win_sum - NREQ_EXT;
        end
        winner = win_sum[IDX_W-1:0];
    end

    // Priority pointer after a transaction: the requester after the owner.
    always_comb begin
        owner_inc = (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
    end

    // Decode the events that move the state machine.
    always_comb begin
        grant_fire = (state == IDLE) && (|req);
        wait_done  = (state == WAIT) && ds;
        wait_tmo   = (state == WAIT) && !ds && (cnt == TMO_LAST);
        in_release = (state == RELEASE);
    end

    // Main sequencing state machine: IDLE -> ISSUE -> WAIT -> RELEASE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (grant_fire)            state <= ISSUE;
                ISSUE:                              state <= WAIT;
                WAIT:    if (wait_done || wait_tmo) state <= RELEASE;
                RELEASE:                            state <= IDLE;
                default:                            state <= IDLE;
            endcase
        end
    end

    // Watchdog: cleared on leaving ISSUE, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    // Single-cycle start pulse: raised with the grant, dropped out of ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            go <= 1'b0;
        end else if (grant_fire) begin
            go <= 1'b1;
        end else if (state == ISSUE) begin
            go <= 1'b0;
        end
    end

    // Grant, owner and busy: set on grant, grant/busy cleared at RELEASE exit;
    // owner keeps the last grantee while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
        end else if (grant_fire) begin
            gnt   <= NREQ'(1) << winner;
            owner <= winner;
            busy  <= 1'b1;
        end else if (in_release) begin
            gnt   <= '0;
            busy  <= 1'b0;
        end
    end

    // Completion/timeout pulses to the owner; ds wins over a same-cycle
    // timeout, and both pulses last exactly the RELEASE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_o <= '0;
            err_o  <= '0;
        end else if (wait_done) begin
            done_o <= NREQ'(1) << owner;
        end else if (wait_tmo) begin
            err_o  <= NREQ'(1) << owner;
        end else if (in_release) begin
            done_o <= '0;
            err_o  <= '0;
        end
    end

    // Rotate priority once the owner's transaction is finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (in_release) begin
            ptr <= owner_inc;
        end
    end

endmodule

// File: tb/tb_read_arbiter.sv
// tb_read_arbiter
// Directed scenarios followed by a randomized phase for read_arbiter. The
// expected outputs come from a transaction-level model that tracks the
// current owner and how many cycles have elapsed since its grant.

module tb_read_arbiter;

    localparam int NREQ    = 4;
    localparam int IDX_W   = 2;
    localparam int TMO_W   = 8;
    localparam int TMO_MAX = 200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic             ds  = 1'b0;
    logic             go;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] owner;
    logic [NREQ-1:0]  done_o;
    logic [NREQ-1:0]  err_o;
    logic             busy;

    read_arbiter #(
        .NREQ    (NREQ),
        .IDX_W   (IDX_W),
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ds     (ds),
        .go     (go),
        .gnt    (gnt),
        .owner  (owner),
        .done_o (done_o),
        .err_o  (err_o),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: one transaction in flight at most.
    // m_age counts edges since the grant edge (0 = go cycle); the outcome
    // (1 = done, 2 = timeout) is decided at age m_end and the grant is
    // released one cycle later.
    int m_active = 0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_age    = 0;
    int m_kind   = 0;
    int m_end    = 0;

    // Stimulus controls
    int ds_age = 0;      // age at which the engine answers (0 = never)
    bit stray  = 1'b0;   // drive ds outside WAIT
    logic [NREQ-1:0] rq;

    int go_log[$];
    int done_cnt[NREQ];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int from);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (from + k) % NREQ;
            if (((r >> idx) & NREQ'(1)) != '0) return idx;
        end
        return from;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_active = 0;
            m_owner  = 0;
            m_ptr    = 0;
            m_kind   = 0;
        end else if (m_active == 0) begin
            if (req != '0) begin
                m_owner  = rr_pick(req, m_ptr);
                m_active = 1;
                m_age    = 0;
                m_kind   = 0;
            end
        end else begin
            m_age++;
            if (m_kind != 0) begin
                if (m_age == m_end + 1) begin
                    m_active = 0;
                    m_ptr    = (m_owner + 1) % NREQ;
                end
            end else if (m_age >= 2) begin
                if (ds) begin
                    m_kind = 1;
                    m_end  = m_age;
                end else if (m_age == TMO_MAX + 1) begin
                    m_kind = 2;
                    m_end  = m_age;
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic             e_go;
        logic [NREQ-1:0]  e_gnt;
        logic [NREQ-1:0]  e_done;
        logic [NREQ-1:0]  e_err;
        logic             e_busy;
        e_go   = (m_active != 0) && (m_age == 0);
        e_gnt  = (m_active != 0) ? (NREQ'(1) << m_owner) : '0;
        e_done = (m_active != 0 && m_kind == 1 && m_age == m_end) ? (NREQ'(1) << m_owner) : '0;
        e_err  = (m_active != 0 && m_kind == 2 && m_age == m_end) ? (NREQ'(1) << m_owner) : '0;
        e_busy = (m_active != 0);
        return {e_go, e_gnt, IDX_W'(m_owner), e_done, e_err, e_busy};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {go, gnt, owner, done_o, err_o, busy};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, step the model, compare.
    task automatic cyc(input logic [NREQ-1:0] r, input string tag);
        req = r;
        ds  = ((m_active != 0) && (m_kind == 0) && (ds_age > 0) && (m_age + 1 == ds_age))
              || (stray && !((m_active != 0) && (m_kind == 0) && (m_age >= 1)));
        @(posedge clk);
        model_update();
        #1;
        chk(tag, obs_vec(), exp_vec());
        if (go === 1'b1) go_log.push_back(int'(owner));
        for (int k = 0; k < NREQ; k++) begin
            if (done_o[k] === 1'b1) done_cnt[k]++;
        end
    endtask

    task automatic finish_txn(input logic [NREQ-1:0] r, input string tag);
        for (int i = 0; i < 400 && m_active != 0; i++) cyc(r, tag);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        cyc('0, "reset");
        cyc('0, "reset");
        chk("reset_outputs", obs_vec(), 16'h0000);
        rst = 1'b0;

        // 1. Single request, ds three cycles after go
        ds_age = 3;
        cyc(4'b0100, "t1_grant");
        chk("t1_go_gnt_owner", 16'({go, gnt, owner}), 16'({1'b1, 4'b0100, 2'd2}));
        cyc(4'b0100, "t1_issue");
        chk("t1_go_one_cycle", 16'(go), 16'(1'b0));
        cyc(4'b0100, "t1_wait");
        cyc(4'b0100, "t1_ds");
        chk("t1_done", 16'({done_o, err_o}), 16'({4'b0100, 4'b0000}));
        cyc(4'b0100, "t1_release");
        chk("t1_release", 16'({gnt, busy, done_o}), 16'h0000);
        cyc(4'b1011, "t1_ptr");
        chk("t1_ptr_is_3", 16'(owner), 16'(2'd3));
        finish_txn(4'b1011, "t1_ptr_finish");

        // 2. Round-robin fairness from a fresh pointer
        rst = 1'b1;
        cyc('0, "t2_reset");
        rst = 1'b0;
        go_log.delete();
        for (int k = 0; k < NREQ; k++) done_cnt[k] = 0;
        ds_age = 3;
        for (int i = 0; i < 100 && go_log.size() < 6; i++) cyc(4'b1111, "t2_rr");
        finish_txn('0, "t2_finish");
        chk("t2_grants", 16'(go_log.size()), 16'd6);
        for (int i = 0; i < 6; i++) begin
            chk("t2_order", 16'((i < go_log.size()) ? go_log[i] : 99), 16'(exp_order[i]));
        end
        for (int k = 0; k < NREQ; k++) begin
            int n_exp;
            n_exp = 0;
            for (int i = 0; i < 6; i++) if (exp_order[i] == k) n_exp++;
            chk("t2_done_count", 16'(done_cnt[k]), 16'(n_exp));
        end

        // 3. Timeout: no ds at all
        ds_age = 0;
        cyc(4'b0010, "t3_grant");
        chk("t3_owner", 16'(owner), 16'(2'd1));
        for (int i = 0; i < TMO_MAX; i++) cyc('0, "t3_wait");
        chk("t3_no_err_early", 16'(err_o), 16'h0000);
        cyc('0, "t3_tmo");
        chk("t3_err", 16'({done_o, err_o}), 16'({4'b0000, 4'b0010}));
        cyc('0, "t3_release");
        chk("t3_gnt_cleared", 16'({gnt, busy}), 16'h0000);

        // 4a. ds on the same cycle as the timeout: done wins
        ds_age = TMO_MAX + 1;
        cyc(4'b0001, "t4_grant");
        for (int i = 0; i < TMO_MAX; i++) cyc('0, "t4_wait");
        cyc('0, "t4_collide");
        chk("t4_collision", 16'({done_o, err_o}), 16'({4'b0001, 4'b0000}));
        finish_txn('0, "t4_finish");

        // 4b. Stray ds in IDLE, ISSUE and RELEASE
        stray  = 1'b1;
        ds_age = 5;
        cyc('0, "t4_stray_idle");
        chk("t4_stray_idle", 16'({busy, done_o, err_o}), 16'h0000);
        cyc(4'b0100, "t4_stray_grant");
        cyc('0, "t4_stray_issue");
        chk("t4_stray_issue", 16'({busy, done_o}), 16'({1'b1, 4'b0000}));
        finish_txn('0, "t4_stray_finish");
        stray = 1'b0;

        // 5. Reset in WAIT with owner 3
        ds_age = 0;
        cyc(4'b1000, "t5_grant");
        chk("t5_owner", 16'(owner), 16'(2'd3));
        for (int i = 0; i < 3; i++) cyc('0, "t5_wait");
        rst = 1'b1;
        cyc('0, "t5_rst");
        rst = 1'b0;
        chk("t5_after_rst", obs_vec(), 16'h0000);
        ds_age = 4;
        cyc(4'b1001, "t5_regrant");
        chk("t5_first_after_rst", 16'({gnt, owner}), 16'({4'b0001, 2'd0}));
        finish_txn('0, "t5_finish");

        // 6. Request withdrawn during WAIT
        ds_age = 5;
        cyc(4'b1010, "t6_grant");
        chk("t6_owner", 16'(owner), 16'(2'd1));
        cyc(4'b1010, "t6_issue");
        cyc(4'b1010, "t6_wait");
        cyc(4'b1000, "t6_drop");
        cyc(4'b1000, "t6_drop");
        chk("t6_gnt_held", 16'(gnt), 16'(4'b0010));
        cyc(4'b1000, "t6_ds");
        chk("t6_done", 16'(done_o), 16'(4'b0010));
        cyc(4'b1000, "t6_release");
        cyc(4'b1000, "t6_next");
        chk("t6_next_owner", 16'({gnt, owner}), 16'({4'b1000, 2'd3}));
        finish_txn('0, "t6_finish");

        // Randomized phase
        rq = '0;
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stray = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) rq = NREQ'($urandom);
            cyc(rq, "random");
            if (m_active != 0 && m_age == 0) begin
                case ($urandom_range(0, 19))
                    0:       ds_age = 0;
                    1:       ds_age = TMO_MAX + 1;
                    default: ds_age = int'($urandom_range(2, 12));
                endcase
            end
        end
        rst   = 1'b0;
        stray = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
